uart_rx_frame: RTL and testbench

Standalone UART receiver with 16x oversampling. It is the receiving end for frames produced by the team's UART transmitter: 1 start bit, 8 data bits LSB first, an optional even/odd parity bit, and 1 stop bit. It runs on the divided system clock and delivers each received byte as a one-cycle valid pulse with parity and framing status. It feeds the byte-display/command logic.

---
 rtl/uart_rx_frame.sv | 278 +++++++++++++++++++++++++++
 tb/tb_uart_rx_frame.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame.sv
// -----------------------------------------------------------------------------
// uart_rx_frame
//
// UART receiver with 16x oversampling. It receives frames of 1 start bit,
// 8 data bits (LSB first), an optional even/odd parity bit and 1 stop bit.
// Each finished frame produces a one-cycle rx_valid pulse. On that same cycle
// rx_data, parity_err and frame_err are updated, and they hold until the next
// pulse. Every bit is decided by a majority vote of three oversamples taken
// around mid-bit.
//
// Parameters
//   BAUD_DIV     clk cycles per oversample tick (one bit = 16*BAUD_DIV clk)
//   SYNC_STAGES  flops in the rxd synchronizer (values below 2 are raised to 2)
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset; aborts any frame in progress
//   parity_en    1 = frame carries a parity bit (latched at the start edge)
//   parity_kind  0 = even, 1 = odd parity (latched at the start edge)
//   rxd          serial line, idle high, asynchronous to clk
//   rx_data      last received byte
//   rx_valid     one-cycle pulse: frame complete, status outputs updated
//   parity_err   parity mismatch on the last frame
//   frame_err    stop bit sampled low on the last frame
//   busy         high from start-edge detection until the return to IDLE
// -----------------------------------------------------------------------------
module uart_rx_frame #(
  parameter int BAUD_DIV    = 163,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       parity_en,
  input  logic       parity_kind,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int DIV_W  = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BAUD_DIV - 1);

  // Oversample counts that bracket mid-bit, plus the last count of a bit.
  localparam logic [3:0] SAMP_A    = 4'd7;
  localparam logic [3:0] SAMP_B    = 4'd8;
  localparam logic [3:0] SAMP_C    = 4'd9;
  localparam logic [3:0] SAMP_LAST = 4'd15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  state_t state_q, state_d;

  // ---------------------------------------------------------------------------
  // Input synchronizer and edge detect
  // ---------------------------------------------------------------------------
  logic [SYNC_N-1:0] sync_q;
  logic              rxs;
  logic              rxs_d;
  logic              fall;

  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge value of its inputs, whatever the statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      rxs_d  <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_N-2:0], rxd};
      rxs_d  <= rxs;
    end
  end

  assign rxs  = sync_q[SYNC_N-1];
  assign fall = rxs_d & ~rxs;

  // ---------------------------------------------------------------------------
  // Oversample tick generator
  // Held at 0 in IDLE, so the first tick of a frame lands exactly BAUD_DIV
  // cycles after the start edge. In BREAK it is also held while the line is
  // low, so the high-time count only advances during a continuous high level.
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] div_cnt;
  logic             div_run;
  logic             tick;

  assign div_run = (state_q != S_IDLE) && !((state_q == S_BREAK) && !rxs);
  assign tick    = div_run && (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (!div_run || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Sample counter and majority vote
  // Samples at counts 7 and 8 are stored. The live sample at count 9 completes
  // the vote, and the decision is acted on during that count-9 tick.
  // ---------------------------------------------------------------------------
  logic [3:0] samp_cnt;
  logic       samp_clr;
  logic       vote_a;
  logic       vote_b;
  logic       vote;
  logic       decide;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_cnt <= '0;
    end else if (samp_clr) begin
      samp_cnt <= '0;
    end else if (tick) begin
      samp_cnt <= samp_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vote_a <= 1'b1;
      vote_b <= 1'b1;
    end else begin
      if (tick && (samp_cnt == SAMP_A)) vote_a <= rxs;
      if (tick && (samp_cnt == SAMP_B)) vote_b <= rxs;
    end
  end

  assign vote   = (vote_a & vote_b) | (vote_a & rxs) | (vote_b & rxs);
  assign decide = tick && (samp_cnt == SAMP_C);

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  logic [2:0] bit_cnt;
  logic       start_seen;
  logic       shift_en;
  logic       par_chk;
  logic       frame_done;
  logic       par_en_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every output of this block gets a default before the case statement,
  // so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    samp_clr   = 1'b0;
    start_seen = 1'b0;
    shift_en   = 1'b0;
    par_chk    = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        samp_clr = 1'b1;
        if (fall) begin
          start_seen = 1'b1;
          state_d    = S_START;
        end
      end
      S_START: begin
        // A high vote at mid start bit is a glitch, not a frame.
        if (decide) state_d = vote ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (decide) begin
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) state_d = par_en_q ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (decide) begin
          par_chk = 1'b1;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (decide) begin
          frame_done = 1'b1;
          // Leave at mid stop bit so a back-to-back start edge is not missed.
          if (vote) begin
            state_d = S_IDLE;
          end else begin
            state_d  = S_BREAK;
            samp_clr = 1'b1;
          end
        end
      end
      S_BREAK: begin
        // Any low level restarts the 16-tick high-time qualification.
        if (!rxs) begin
          samp_clr = 1'b1;
        end else if (tick && (samp_cnt == SAMP_LAST)) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy = (state_q != S_IDLE);

  // ---------------------------------------------------------------------------
  // Datapath: configuration latch, shift register, bit counter, parity check
  // ---------------------------------------------------------------------------
  logic [7:0] shift_q;
  logic       perr_q;
  logic       par_kind_q;

  // NOTE: these are individual flops, not a RAM, so they take the async reset
  // like the rest of the state. The shift register value is only used once a
  // full frame has been shifted in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q    <= '0;
      bit_cnt    <= '0;
      perr_q     <= 1'b0;
      par_en_q   <= 1'b0;
      par_kind_q <= 1'b0;
    end else begin
      if (start_seen) begin
        par_en_q   <= parity_en;
        par_kind_q <= parity_kind;
        perr_q     <= 1'b0;
        bit_cnt    <= '0;
      end
      if (shift_en) begin
        shift_q <= {vote, shift_q[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
      // Expected parity bit is XOR of the data, inverted for odd parity.
      if (par_chk) begin
        perr_q <= vote ^ (^shift_q) ^ par_kind_q;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output registers: updated only on the frame-complete cycle
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_valid <= frame_done;
      if (frame_done) begin
        rx_data    <= shift_q;
        parity_err <= perr_q;
        frame_err  <= ~vote;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_frame
//
// Directed testbench for uart_rx_frame with BAUD_DIV=4, so one bit is 64 clk.
// All stimulus changes on the falling clock edge. A monitor records every
// rx_valid pulse together with its data, status flags and cycle stamp, and the
// main sequence compares those records against hand-computed values.
// -----------------------------------------------------------------------------
module tb_uart_rx_frame;

  localparam int BAUD_DIV = 4;
  localparam int BIT_CLK  = 16 * BAUD_DIV;

  // Start edge driven at falling edge 0. The line reaches rxs after 2 rising
  // edges, and the FSM enters START at edge 3. Tick k (k = 0,1,...) then falls
  // in the cycle after edge 6+4k. The stop-bit decision is k = 16*9+9 = 153,
  // which is the cycle after edge 618, so rx_valid is seen after edge 619.
  localparam int LAT_NO_PAR = 619;

  logic       clk         = 1'b0;
  logic       rst_n       = 1'b0;
  logic       parity_en   = 1'b0;
  logic       parity_kind = 1'b0;
  logic       rxd         = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  uart_rx_frame #(
    .BAUD_DIV   (BAUD_DIV),
    .SYNC_STAGES(2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .parity_en  (parity_en),
    .parity_kind(parity_kind),
    .rxd        (rxd),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] got_q[$];
  logic       perr_q[$];
  logic       ferr_q[$];
  int         cyc_q[$];
  logic       busy_after = 1'b1;
  logic       prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (prev_valid) busy_after = busy;
    prev_valid = rx_valid;
    if (rx_valid) begin
      got_q.push_back(rx_data);
      perr_q.push_back(parity_err);
      ferr_q.push_back(frame_err);
      cyc_q.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic void clear_mon();
    got_q.delete();
    perr_q.delete();
    ferr_q.delete();
    cyc_q.delete();
  endfunction

  // Accessors return all-ones when no record exists, which never matches an
  // expected value here.
  function automatic logic [31:0] rx_at(input int i);
    if (i < got_q.size()) return {24'h0, got_q[i]};
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] perr_at(input int i);
    if (i < perr_q.size()) return {31'h0, perr_q[i]};
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] ferr_at(input int i);
    if (i < ferr_q.size()) return {31'h0, ferr_q[i]};
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] cyc_at(input int i);
    if (i < cyc_q.size()) return cyc_q[i];
    return 32'hFFFF_FFFF;
  endfunction

  // Drives one frame. Call on a falling edge; returns on a falling edge with
  // rxd left at the stop-bit level.
  task automatic send_frame(input logic [7:0] d, input bit has_par, input bit par_bit,
                            input bit stop_bit, input int bclk);
    rxd = 1'b0;
    repeat (bclk) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      repeat (bclk) @(negedge clk);
    end
    if (has_par) begin
      rxd = par_bit;
      repeat (bclk) @(negedge clk);
    end
    rxd = stop_bit;
    repeat (bclk) @(negedge clk);
  endtask

  logic [7:0] b2b[4]  = '{8'h00, 8'hFF, 8'h81, 8'h7E};
  int         skew[2] = '{66, 62};
  int         c0;

  initial begin
    // ---------------- reset state ----------------
    repeat (3) @(negedge clk);
    check("rst_data",  rx_data,    32'h0);
    check("rst_valid", rx_valid,   32'h0);
    check("rst_perr",  parity_err, 32'h0);
    check("rst_ferr",  frame_err,  32'h0);
    check("rst_busy",  busy,       32'h0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // ---------------- basic frame 0xA5, no parity ----------------
    clear_mon();
    c0 = cyc;
    fork
      send_frame(8'hA5, 1'b0, 1'b0, 1'b1, BIT_CLK);
      begin
        repeat (BIT_CLK * 3) @(negedge clk);
        check("basic_busy_mid", busy, 32'h1);
      end
    join
    repeat (20) @(negedge clk);
    check("basic_count",      got_q.size(),  32'd1);
    check("basic_data",       rx_at(0),      32'hA5);
    check("basic_perr",       perr_at(0),    32'h0);
    check("basic_ferr",       ferr_at(0),    32'h0);
    check("basic_latency",    cyc_at(0) - c0, LAT_NO_PAR);
    check("basic_busy_after", busy_after,    32'h0);

    // ---------------- parity ----------------
    parity_en   = 1'b1;
    parity_kind = 1'b0;
    clear_mon();
    send_frame(8'h07, 1'b1, 1'b1, 1'b1, BIT_CLK);   // even: 3 ones -> bit 1
    repeat (20) @(negedge clk);
    check("par_even_ok_count", got_q.size(), 32'd1);
    check("par_even_ok_data",  rx_at(0),     32'h07);
    check("par_even_ok_perr",  perr_at(0),   32'h0);

    clear_mon();
    send_frame(8'h07, 1'b1, 1'b0, 1'b1, BIT_CLK);   // wrong even parity
    repeat (20) @(negedge clk);
    check("par_even_bad_count", got_q.size(), 32'd1);
    check("par_even_bad_data",  rx_at(0),     32'h07);
    check("par_even_bad_perr",  perr_at(0),   32'h1);
    check("par_even_bad_ferr",  ferr_at(0),   32'h0);

    parity_kind = 1'b1;
    clear_mon();
    send_frame(8'h07, 1'b1, 1'b0, 1'b1, BIT_CLK);   // odd: 3 ones -> bit 0
    repeat (20) @(negedge clk);
    check("par_odd_ok_perr", perr_at(0), 32'h0);

    // Configuration flipped mid-frame must not affect the frame in flight.
    parity_kind = 1'b0;
    clear_mon();
    fork
      send_frame(8'h07, 1'b1, 1'b1, 1'b1, BIT_CLK);
      begin
        repeat (BIT_CLK * 4) @(negedge clk);
        parity_kind = 1'b1;
        parity_en   = 1'b0;
      end
    join
    repeat (20) @(negedge clk);
    check("par_latch_count", got_q.size(), 32'd1);
    check("par_latch_perr",  perr_at(0),   32'h0);
    parity_en   = 1'b0;
    parity_kind = 1'b0;

    // ---------------- false start ----------------
    clear_mon();
    rxd = 1'b0;
    repeat (10) @(negedge clk);
    check("fs_busy_start", busy, 32'h1);
    repeat (10) @(negedge clk);
    rxd = 1'b1;
    repeat (100) @(negedge clk);
    check("fs_count", got_q.size(), 32'd0);
    check("fs_busy",  busy,         32'h0);
    check("fs_data",  rx_data,      32'h07);

    // ---------------- single-sample glitch in data bit 3 of 0x00 ----------------
    // Bit 3 occupies falling edges 256..319; its votes read the line as driven
    // at falling edges 288, 292 and 296. The glitch covers only 292.
    clear_mon();
    fork
      send_frame(8'h00, 1'b0, 1'b0, 1'b1, BIT_CLK);
      begin
        repeat (BIT_CLK * 4 + 36) @(negedge clk);
        rxd = 1'b1;
        repeat (2) @(negedge clk);
        rxd = 1'b0;
      end
    join
    repeat (20) @(negedge clk);
    check("glitch_count", got_q.size(), 32'd1);
    check("glitch_data",  rx_at(0),     32'h00);

    // ---------------- framing error and break ----------------
    clear_mon();
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, BIT_CLK);
    repeat (BIT_CLK * 3) @(negedge clk);
    rxd = 1'b1;
    repeat (40) @(negedge clk);
    check("brk_busy_hold", busy, 32'h1);
    rxd = 1'b0;                                       // low edge inside BREAK
    repeat (40) @(negedge clk);
    rxd = 1'b1;
    repeat (100) @(negedge clk);
    check("brk_count", got_q.size(), 32'd1);
    check("brk_data",  rx_at(0),     32'h3C);
    check("brk_ferr",  ferr_at(0),   32'h1);
    check("brk_perr",  perr_at(0),   32'h0);
    check("brk_idle",  busy,         32'h0);

    clear_mon();
    send_frame(8'h55, 1'b0, 1'b0, 1'b1, BIT_CLK);
    repeat (20) @(negedge clk);
    check("post_brk_count", got_q.size(), 32'd1);
    check("post_brk_data",  rx_at(0),     32'h55);
    check("post_brk_ferr",  ferr_at(0),   32'h0);

    // ---------------- back-to-back frames at +/-3% baud ----------------
    for (int s = 0; s < 2; s++) begin
      clear_mon();
      for (int f = 0; f < 4; f++) begin
        send_frame(b2b[f], 1'b0, 1'b0, 1'b1, skew[s]);
      end
      repeat (100) @(negedge clk);
      check($sformatf("b2b%0d_count", skew[s]), got_q.size(), 32'd4);
      for (int f = 0; f < 4; f++) begin
        check($sformatf("b2b%0d_data%0d", skew[s], f), rx_at(f), {24'h0, b2b[f]});
        check($sformatf("b2b%0d_ferr%0d", skew[s], f), ferr_at(f), 32'h0);
      end
    end

    // ---------------- reset during data bit 4 ----------------
    clear_mon();
    fork
      send_frame(8'h99, 1'b0, 1'b0, 1'b1, BIT_CLK);
      begin
        repeat (BIT_CLK * 5 + 30) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rmid_data",  rx_data,    32'h0);
        check("rmid_valid", rx_valid,   32'h0);
        check("rmid_perr",  parity_err, 32'h0);
        check("rmid_ferr",  frame_err,  32'h0);
        check("rmid_busy",  busy,       32'h0);
      end
    join
    @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    check("rmid_no_valid", got_q.size(), 32'd0);
    send_frame(8'h12, 1'b0, 1'b0, 1'b1, BIT_CLK);
    repeat (20) @(negedge clk);
    check("rmid_next_count", got_q.size(), 32'd1);
    check("rmid_next_data",  rx_at(0),     32'h12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
